// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack port, presents
// each instruction for one EXEC cycle, then advances, branches, or halts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        ill_instr,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] trap_pc
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_MIS = 2'b10;

  logic [1:0]  state;
  logic [31:0] br_target;

  assign br_target   = pc + branch_offset;
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      instr      <= NOP;
      halted     <= 1'b0;
      halt_cause <= 2'b00;
      trap_pc    <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Trap checks take precedence; the pc stays on the faulting instruction.
          if (ill_instr) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_ILL;
            trap_pc    <= pc;
          end else if (branch_taken && (br_target[1:0] != 2'b00)) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_MIS;
            trap_pc    <= pc;
          end else if (branch_taken) begin
            pc    <= br_target;
            state <= FETCH;
          end else begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
